sync_fifo_flags: RTL and testbench

Parametrised single-clock FIFO, next generation of the team's synchronous FIFO. Adds:
- occupancy count
- programmable almost-full/almost-empty thresholds
- sticky-free overflow/underflow error pulses
- synchronous flush
- selectable first-word-fall-through (FWFT) read mode

Sits between producer/consumer pipeline stages in the same clock domain.

---
 rtl/sync_fifo_flags.sv | 115 +++++++++++
 tb/tb_sync_fifo_flags.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// ---------------------------------------------------------------------------
// sync_fifo_flags
//   Single-clock FIFO with occupancy count, programmable almost-full and
//   almost-empty thresholds, one-cycle overflow/underflow error pulses,
//   synchronous flush and a selectable first-word-fall-through read mode.
//
// Ports
//   clk          rising-edge clock for all state
//   rst_n        asynchronous active-low reset
//   flush        synchronous clear of pointers/count/error pulses
//   w_en         write request, accepted when not full
//   data_in      write data
//   r_en         read request (FWFT: pop of the visible head word)
//   data_out     read data (registered in standard mode, live head in FWFT)
//   full         count == DEPTH
//   empty        count == 0
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   count        occupancy, 0..DEPTH
//   overflow     one-cycle pulse after a write attempt while full
//   underflow    one-cycle pulse after a read attempt while empty
// ---------------------------------------------------------------------------
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 2,
  parameter int FWFT       = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       w_en,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic                       r_en,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         w_ptr;
  logic [PW-1:0]         r_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // Pointers carry one extra wrap bit, so their difference is the occupancy
  // 0..DEPTH. Count and every flag are therefore pure functions of registered
  // state: w_en/r_en never reach a flag combinationally.
  assign count        = w_ptr - r_ptr;
  assign full         = (count == PW'(DEPTH));
  assign empty        = (count == '0);
  assign almost_full  = (count >= PW'(AF_LEVEL));
  assign almost_empty = (count <= PW'(AE_LEVEL));

  // A write while full is refused even if a read is accepted on the same edge.
  assign wr_acc = w_en & ~full;
  assign rd_acc = r_en & ~empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + PW'(1);
      if (rd_acc) r_ptr <= r_ptr + PW'(1);
      overflow  <= w_en & full;
      underflow <= r_en & empty;
    end
  end

  // NOTE: the storage array has no reset; stale words are unreachable because
  // the pointers define what is valid, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (!flush && wr_acc) mem[w_ptr[AW-1:0]] <= data_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is presented directly; only meaningful while !empty.
      assign data_out = mem[r_ptr[AW-1:0]];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] data_q;

      // Updates only on an accepted read; holds through flush and rejected reads.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_q <= '0;
        end else if (!flush && rd_acc) begin
          data_q <= mem[r_ptr[AW-1:0]];
        end
      end

      assign data_out = data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
module tb_sync_fifo_flags;

  localparam int DW = 8;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Standard-mode instance
  logic          s_flush = 1'b0, s_w_en = 1'b0, s_r_en = 1'b0;
  logic [DW-1:0] s_data_in = '0, s_data_out;
  logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic [CW-1:0] s_count;

  // FWFT-mode instance
  logic          f_flush = 1'b0, f_w_en = 1'b0, f_r_en = 1'b0;
  logic [DW-1:0] f_data_in = '0, f_data_out;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [CW-1:0] f_count;

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .flush(s_flush), .w_en(s_w_en), .data_in(s_data_in),
    .r_en(s_r_en), .data_out(s_data_out), .full(s_full), .empty(s_empty),
    .almost_full(s_af), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1)) u_fwft (
    .clk(clk), .rst_n(rst_n), .flush(f_flush), .w_en(f_w_en), .data_in(f_data_in),
    .r_en(f_r_en), .data_out(f_data_out), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ovf), .underflow(f_unf)
  );

  int checks = 0;
  int errors = 0;

  // Reference model for the standard instance
  logic [DW-1:0] sb [$];
  logic [DW-1:0] fsb [$];
  int            exp_count = 0;
  logic [DW-1:0] exp_dout = '0;
  logic          exp_ovf = 1'b0;
  logic          exp_unf = 1'b0;

  // One clock of stimulus on the standard instance; starts and ends at a negedge.
  task automatic do_cycle(input logic we, input logic [DW-1:0] d, input logic re, input logic fl);
    logic wa, ra;
    wa = !fl && we && (exp_count < DEPTH);
    ra = !fl && re && (exp_count > 0);
    exp_ovf = !fl && we && (exp_count == DEPTH);
    exp_unf = !fl && re && (exp_count == 0);
    s_w_en = we; s_data_in = d; s_r_en = re; s_flush = fl;
    @(posedge clk);
    if (fl) begin
      sb.delete();
      exp_count = 0;
    end else begin
      if (ra) exp_dout = sb.pop_front();
      if (wa) sb.push_back(d);
      exp_count = exp_count + int'(wa) - int'(ra);
    end
    @(negedge clk);
    s_w_en = 1'b0; s_r_en = 1'b0; s_flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_count !== 0 || s_empty !== 1'b1 || s_full !== 1'b0 || s_ae !== 1'b1 ||
        s_af !== 1'b0 || s_data_out !== 8'h00 || s_ovf !== 1'b0 || s_unf !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: count=%0d empty=%b full=%b ae=%b af=%b dout=%h ovf=%b unf=%b, want 0 1 0 1 0 00 0 0",
               s_count, s_empty, s_full, s_ae, s_af, s_data_out, s_ovf, s_unf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Reach count 5 with a nonzero data_out, then reset mid-cycle.
    for (int i = 0; i < 6; i++) do_cycle(1'b1, DW'(8'h01 + i), 1'b0, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (s_count !== CW'(exp_count) || s_data_out !== exp_dout) begin
      errors++;
      $display("FAIL pre_reset: count=%0d dout=%h, want %0d %h", s_count, s_data_out, exp_count, exp_dout);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s_count !== 0 || s_empty !== 1'b1 || s_ae !== 1'b1 || s_full !== 1'b0 || s_data_out !== 8'h00) begin
      errors++;
      $display("FAIL async_reset: count=%0d empty=%b ae=%b full=%b dout=%h, want 0 1 1 0 00",
               s_count, s_empty, s_ae, s_full, s_data_out);
    end
    sb.delete(); exp_count = 0; exp_dout = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b1, DW'(8'h10 + i), 1'b0, 1'b0);
      checks++;
      if (s_count !== CW'(i + 1) || s_af !== (i + 1 >= 6) || s_full !== (i + 1 == DEPTH) || s_empty !== 1'b0) begin
        errors++;
        $display("FAIL fill_%0d: count=%0d af=%b full=%b empty=%b, want %0d %b %b 0",
                 i, s_count, s_af, s_full, s_empty, i + 1, (i + 1 >= 6), (i + 1 == DEPTH));
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      do_cycle(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (s_data_out !== DW'(8'h10 + i) || s_data_out !== exp_dout || s_count !== CW'(exp_count) ||
          s_ae !== (exp_count <= 2) || s_empty !== (exp_count == 0)) begin
        errors++;
        $display("FAIL drain_%0d: dout=%h count=%0d ae=%b empty=%b, want %h %0d %b %b",
                 i, s_data_out, s_count, s_ae, s_empty, exp_dout, exp_count, (exp_count <= 2), (exp_count == 0));
      end
    end
  endtask

  task automatic test_over_under();
    for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, DW'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      do_cycle(1'b1, 8'hEE, 1'b0, 1'b0);
      checks++;
      if (s_ovf !== 1'b1 || s_count !== CW'(DEPTH) || s_full !== 1'b1) begin
        errors++;
        $display("FAIL overflow_%0d: ovf=%b count=%0d full=%b, want 1 %0d 1", i, s_ovf, s_count, s_full, DEPTH);
      end
    end
    // Read and write together while full: read accepted, write refused.
    do_cycle(1'b1, 8'hEF, 1'b1, 1'b0);
    checks++;
    if (s_ovf !== exp_ovf || s_count !== CW'(exp_count) || s_data_out !== exp_dout) begin
      errors++;
      $display("FAIL full_rw: ovf=%b count=%0d dout=%h, want %b %0d %h", s_ovf, s_count, s_data_out, exp_ovf, exp_count, exp_dout);
    end
    do_cycle(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (s_ovf !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: ovf=%b, want 0", s_ovf);
    end
    while (sb.size() > 0) begin
      do_cycle(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (s_data_out !== exp_dout) begin
        errors++;
        $display("FAIL after_overflow_data: dout=%h, want %h", s_data_out, exp_dout);
      end
    end
    do_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (s_unf !== exp_unf || s_unf !== 1'b1 || s_data_out !== exp_dout || s_count !== 0) begin
      errors++;
      $display("FAIL underflow: unf=%b dout=%h count=%0d, want 1 %h 0", s_unf, s_data_out, s_count, exp_dout);
    end
    do_cycle(1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (s_unf !== 1'b0 || s_empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow_clear: unf=%b empty=%b, want 0 1", s_unf, s_empty);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) do_cycle(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      do_cycle(1'b1, DW'(8'h50 + i), 1'b1, 1'b0);
      checks++;
      if (s_count !== 4 || s_data_out !== exp_dout) begin
        errors++;
        $display("FAIL concurrent_%0d: count=%0d dout=%h, want 4 %h", i, s_count, s_data_out, exp_dout);
      end
    end
    while (sb.size() > 0) begin
      do_cycle(1'b0, '0, 1'b1, 1'b0);
      checks++;
      if (s_data_out !== exp_dout || s_count !== CW'(exp_count)) begin
        errors++;
        $display("FAIL concurrent_drain: dout=%h count=%0d, want %h %0d", s_data_out, s_count, exp_dout, exp_count);
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 7; i++) do_cycle(1'b1, DW'(8'h60 + i), 1'b0, 1'b0);
    do_cycle(1'b1, 8'h99, 1'b0, 1'b1);
    checks++;
    if (s_count !== 0 || s_empty !== 1'b1 || s_data_out !== exp_dout || s_ovf !== 1'b0) begin
      errors++;
      $display("FAIL flush: count=%0d empty=%b dout=%h ovf=%b, want 0 1 %h 0", s_count, s_empty, s_data_out, s_ovf, exp_dout);
    end
    do_cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    do_cycle(1'b0, '0, 1'b1, 1'b0);
    checks++;
    if (s_data_out !== 8'hA5 || s_data_out !== exp_dout || s_empty !== 1'b1) begin
      errors++;
      $display("FAIL after_flush: dout=%h empty=%b, want a5 1", s_data_out, s_empty);
    end
  endtask

  task automatic test_fwft();
    f_w_en = 1'b1; f_data_in = 8'h3C; fsb.push_back(8'h3C);
    @(posedge clk); @(negedge clk);
    f_w_en = 1'b0;
    checks++;
    if (f_empty !== 1'b0 || f_data_out !== fsb[0] || f_count !== 1) begin
      errors++;
      $display("FAIL fwft_first: empty=%b dout=%h count=%0d, want 0 %h 1", f_empty, f_data_out, f_count, fsb[0]);
    end
    f_w_en = 1'b1; f_data_in = 8'h3D; fsb.push_back(8'h3D);
    @(posedge clk); @(negedge clk);
    f_w_en = 1'b0;
    checks++;
    if (f_data_out !== fsb[0] || f_count !== 2) begin
      errors++;
      $display("FAIL fwft_hold: dout=%h count=%0d, want %h 2", f_data_out, f_count, fsb[0]);
    end
    f_r_en = 1'b1;
    @(posedge clk); void'(fsb.pop_front()); @(negedge clk);
    f_r_en = 1'b0;
    checks++;
    if (f_data_out !== fsb[0] || f_data_out !== 8'h3D || f_count !== 1 || f_unf !== 1'b0) begin
      errors++;
      $display("FAIL fwft_pop: dout=%h count=%0d unf=%b, want 3d 1 0", f_data_out, f_count, f_unf);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_over_under();
    test_back_to_back();
    test_flush();
    test_fwft();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
